// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pc_unit
//  Purpose  : Program-counter unit. Holds the fetch PC, selects the next PC
//             by priority (reset > exception > interrupt > eret > redirect >
//             stall > sequential step), tracks kernel mode and the saved
//             exception PC, and offers the PC to instruction memory through a
//             valid/ready handshake.
//  Ports    : clk, reset             - clock, synchronous active-high reset
//             stall_i                - hold PC (pipeline hazard)
//             redirect_valid_i/pc_i  - taken branch/jump and its target
//             exc_i, exc_epc_i       - synchronous exception and faulting PC
//             irq_i                  - level interrupt request
//             eret_i                 - return from handler
//             fetch_ready_i          - memory accepts pc_o
//             pc_o, pc_plus_o        - fetch PC and fetch PC + STEP
//             fetch_valid_o          - pc_o is a valid fetch request
//             epc_o, kernel_o        - saved exception PC, handler mode
//             cause_o, trap_o        - trap cause, one-cycle trap-entry pulse
//  Revision : 1.0 - initial release
// ============================================================================
module pc_unit #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      STEP      = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = WIDTH'(32'h0000_0000),
  parameter logic [WIDTH-1:0] EXC_VEC   = WIDTH'(32'h8000_0004),
  parameter logic [WIDTH-1:0] IRQ_VEC   = WIDTH'(32'h8000_0008)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall_i,
  input  logic             redirect_valid_i,
  input  logic [WIDTH-1:0] redirect_pc_i,
  input  logic             exc_i,
  input  logic [WIDTH-1:0] exc_epc_i,
  input  logic             irq_i,
  input  logic             eret_i,
  input  logic             fetch_ready_i,
  output logic [WIDTH-1:0] pc_o,
  output logic [WIDTH-1:0] pc_plus_o,
  output logic             fetch_valid_o,
  output logic [WIDTH-1:0] epc_o,
  output logic             kernel_o,
  output logic [1:0]       cause_o,
  output logic             trap_o
);

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] C_STEP = WIDTH'(STEP);
  // Low address bits that must be zero for an aligned redirect target.
  localparam logic [WIDTH-1:0] C_MASK = WIDTH'(STEP - 1);

  localparam logic [1:0] C_CAUSE_NONE = 2'd0;
  localparam logic [1:0] C_CAUSE_EXC  = 2'd1;
  localparam logic [1:0] C_CAUSE_IRQ  = 2'd2;
  localparam logic [1:0] C_CAUSE_MIS  = 2'd3;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] epc_q, epc_d;
  logic             kernel_q, kernel_d;
  logic [1:0]       cause_q, cause_d;
  logic             trap_q, trap_d;
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] pc_plus_w;
  logic             misaligned_w;

  assign pc_plus_w    = pc_q + C_STEP;
  assign misaligned_w = (redirect_pc_i & C_MASK) != '0;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    epc_d    = epc_q;
    kernel_d = kernel_q;
    cause_d  = cause_q;
    trap_d   = 1'b0;
    valid_d  = valid_q;

    case (state_q)
      ST_BOOT: begin
        // One quiet cycle after reset: PC held, every request ignored.
        state_d = ST_RUN;
        valid_d = 1'b1;
      end
      default: begin
        valid_d = 1'b1;
        if (exc_i) begin
          pc_d     = EXC_VEC;
          epc_d    = exc_epc_i;
          kernel_d = 1'b1;
          cause_d  = C_CAUSE_EXC;
          trap_d   = 1'b1;
        end else if (irq_i && !kernel_q) begin
          pc_d     = IRQ_VEC;
          epc_d    = pc_q;
          kernel_d = 1'b1;
          cause_d  = C_CAUSE_IRQ;
          trap_d   = 1'b1;
        end else if (eret_i && kernel_q) begin
          pc_d     = epc_q;
          kernel_d = 1'b0;
          cause_d  = C_CAUSE_NONE;
        end else if (redirect_valid_i) begin
          if (misaligned_w) begin
            // The faulting point is the current fetch PC, not the bad target.
            pc_d     = EXC_VEC;
            epc_d    = pc_q;
            kernel_d = 1'b1;
            cause_d  = C_CAUSE_MIS;
            trap_d   = 1'b1;
          end else begin
            pc_d = redirect_pc_i;
          end
        end else if (stall_i) begin
          pc_d = pc_q;
        end else if (fetch_ready_i) begin
          // Handshake completes (valid is high in RUN); wraps silently.
          pc_d = pc_plus_w;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_BOOT;
      pc_q     <= RESET_VEC;
      epc_q    <= '0;
      kernel_q <= 1'b0;
      cause_q  <= C_CAUSE_NONE;
      trap_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      epc_q    <= epc_d;
      kernel_q <= kernel_d;
      cause_q  <= cause_d;
      trap_q   <= trap_d;
      valid_q  <= valid_d;
    end
  end

  assign pc_o          = pc_q;
  assign pc_plus_o     = pc_plus_w;
  assign fetch_valid_o = valid_q;
  assign epc_o         = epc_q;
  assign kernel_o      = kernel_q;
  assign cause_o       = cause_q;
  assign trap_o        = trap_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_unit
//  Purpose  : Self-checking bench for pc_unit: a vector table walked one clock
//             per entry on a 32-bit instance, plus hand sequences for reset
//             mid-handler and 8-bit PC wrap-around.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pc_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // 32-bit instance
  logic        reset, stall, rv, exc, irq, eret, rdy;
  logic [31:0] rpc, eepc;
  logic [31:0] pc, pcp, epc;
  logic        val, kern, trap;
  logic [1:0]  cause;

  pc_unit u_dut (
    .clk(clk), .reset(reset), .stall_i(stall), .redirect_valid_i(rv),
    .redirect_pc_i(rpc), .exc_i(exc), .exc_epc_i(eepc), .irq_i(irq),
    .eret_i(eret), .fetch_ready_i(rdy), .pc_o(pc), .pc_plus_o(pcp),
    .fetch_valid_o(val), .epc_o(epc), .kernel_o(kern), .cause_o(cause),
    .trap_o(trap)
  );

  // 8-bit instance for wrap-around
  logic       reset8, rdy8;
  logic [7:0] pc8, pcp8, epc8;
  logic       val8, kern8, trap8;
  logic [1:0] cause8;

  pc_unit #(
    .WIDTH(8), .STEP(4), .RESET_VEC(8'hF4), .EXC_VEC(8'h84), .IRQ_VEC(8'h88)
  ) u_dut8 (
    .clk(clk), .reset(reset8), .stall_i(1'b0), .redirect_valid_i(1'b0),
    .redirect_pc_i(8'h00), .exc_i(1'b0), .exc_epc_i(8'h00), .irq_i(1'b0),
    .eret_i(1'b0), .fetch_ready_i(rdy8), .pc_o(pc8), .pc_plus_o(pcp8),
    .fetch_valid_o(val8), .epc_o(epc8), .kernel_o(kern8), .cause_o(cause8),
    .trap_o(trap8)
  );

  typedef struct {
    logic        stall, rv;
    logic [31:0] rpc;
    logic        exc;
    logic [31:0] eepc;
    logic        irq, eret, rdy;
    logic [31:0] pc;
    logic        val;
    logic [31:0] epc;
    logic        k;
    logic [1:0]  cause;
    logic        trap;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(
    input logic s, input logic r, input logic [31:0] rp, input logic e,
    input logic [31:0] ep, input logic i, input logic er, input logic rd,
    input logic [31:0] xpc, input logic xv, input logic [31:0] xepc,
    input logic xk, input logic [1:0] xc, input logic xt);
    vec_t v;
    v.stall = s;  v.rv = r;  v.rpc = rp;  v.exc = e;  v.eepc = ep;
    v.irq = i;    v.eret = er; v.rdy = rd;
    v.pc = xpc;   v.val = xv; v.epc = xepc; v.k = xk; v.cause = xc; v.trap = xt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    stall = 0; rv = 0; rpc = 0; exc = 0; eepc = 0; irq = 0; eret = 0; rdy = 0;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, " pc"},     pc,   v.pc);
    check({tag, " pcplus"}, pcp,  v.pc + 32'd4);
    check({tag, " valid"},  {31'd0, val},  {31'd0, v.val});
    check({tag, " epc"},    epc,  v.epc);
    check({tag, " kernel"}, {31'd0, kern}, {31'd0, v.k});
    check({tag, " cause"},  {30'd0, cause}, {30'd0, v.cause});
    check({tag, " trap"},   {31'd0, trap}, {31'd0, v.trap});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t r;
    //            stl rv rpc           exc eepc   irq eret rdy | pc            v epc     k c  t
    vecs[0]  = mk(0, 0, 32'h0,        0, 32'h0,  0, 0, 1,  32'h0,        1, 32'h0,   0, 0, 0); // BOOT -> RUN, PC held
    vecs[1]  = mk(0, 0, 32'h0,        0, 32'h0,  0, 0, 1,  32'h4,        1, 32'h0,   0, 0, 0);
    vecs[2]  = mk(0, 0, 32'h0,        0, 32'h0,  0, 0, 1,  32'h8,        1, 32'h0,   0, 0, 0);
    vecs[3]  = mk(0, 0, 32'h0,        0, 32'h0,  0, 0, 0,  32'h8,        1, 32'h0,   0, 0, 0); // not ready
    vecs[4]  = mk(0, 0, 32'h0,        0, 32'h0,  0, 0, 0,  32'h8,        1, 32'h0,   0, 0, 0);
    vecs[5]  = mk(1, 0, 32'h0,        0, 32'h0,  0, 0, 1,  32'h8,        1, 32'h0,   0, 0, 0); // stall beats ready
    vecs[6]  = mk(1, 1, 32'h100,      0, 32'h0,  0, 0, 0,  32'h100,      1, 32'h0,   0, 0, 0); // redirect beats stall
    vecs[7]  = mk(0, 0, 32'h0,        0, 32'h0,  0, 0, 1,  32'h104,      1, 32'h0,   0, 0, 0);
    vecs[8]  = mk(0, 1, 32'h102,      0, 32'h0,  0, 0, 0,  32'h80000004, 1, 32'h104, 1, 3, 1); // misaligned
    vecs[9]  = mk(0, 0, 32'h0,        0, 32'h0,  0, 0, 1,  32'h80000008, 1, 32'h104, 1, 3, 0);
    vecs[10] = mk(0, 0, 32'h0,        0, 32'h0,  0, 1, 0,  32'h104,      1, 32'h104, 0, 0, 0); // eret
    vecs[11] = mk(0, 1, 32'h40,       0, 32'h0,  0, 0, 0,  32'h40,       1, 32'h104, 0, 0, 0);
    vecs[12] = mk(0, 0, 32'h0,        0, 32'h0,  1, 0, 1,  32'h80000008, 1, 32'h40,  1, 2, 1); // irq
    vecs[13] = mk(0, 0, 32'h0,        0, 32'h0,  1, 0, 1,  32'h8000000C, 1, 32'h40,  1, 2, 0); // irq masked
    vecs[14] = mk(0, 0, 32'h0,        0, 32'h0,  1, 1, 1,  32'h40,       1, 32'h40,  0, 0, 0); // eret beats masked irq
    vecs[15] = mk(0, 1, 32'h200,      1, 32'h20, 1, 0, 1,  32'h80000004, 1, 32'h20,  1, 1, 1); // exc wins all
    vecs[16] = mk(0, 0, 32'h0,        1, 32'h24, 0, 0, 0,  32'h80000004, 1, 32'h24,  1, 1, 1); // nested exc
    vecs[17] = mk(0, 1, 32'h300,      0, 32'h0,  0, 0, 0,  32'h300,      1, 32'h24,  1, 1, 0); // redirect in kernel
    vecs[18] = mk(1, 0, 32'h0,        0, 32'h0,  0, 1, 0,  32'h24,       1, 32'h24,  0, 0, 0); // eret beats stall
    vecs[19] = mk(0, 0, 32'h0,        0, 32'h0,  0, 1, 1,  32'h28,       1, 32'h24,  0, 0, 0); // user eret ignored
    vecs[20] = mk(1, 0, 32'h0,        0, 32'h0,  1, 0, 0,  32'h80000008, 1, 32'h28,  1, 2, 1); // irq beats stall

    idle_inputs();
    reset = 1; reset8 = 1; rdy8 = 0;
    @(posedge clk); #1;
    r = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
    check_all("reset", r);

    reset = 0;
    for (int i = 0; i < NV; i++) begin
      stall = vecs[i].stall; rv = vecs[i].rv; rpc = vecs[i].rpc;
      exc = vecs[i].exc; eepc = vecs[i].eepc; irq = vecs[i].irq;
      eret = vecs[i].eret; rdy = vecs[i].rdy;
      @(posedge clk); #1;
      check_all($sformatf("vec%0d", i), vecs[i]);
    end

    // Reset while in the handler: everything back to reset values.
    idle_inputs();
    reset = 1;
    @(posedge clk); #1;
    r = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
    check_all("midreset", r);

    // BOOT ignores an exception and holds the PC for one cycle.
    reset = 0; exc = 1; eepc = 32'h44; rdy = 1;
    @(posedge clk); #1;
    r = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 32'h0, 0, 0, 0);
    check_all("boot_ignore", r);
    exc = 0;
    @(posedge clk); #1;
    r = mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 1, 32'h0, 0, 0, 0);
    check_all("after_boot", r);
    idle_inputs();

    // 8-bit wrap: F4 (boot) -> F4 -> F8 -> FC -> 00.
    reset8 = 0; rdy8 = 1;
    check("w8 boot valid", {31'd0, val8}, 32'd0);
    @(posedge clk); #1;
    check("w8 pc0", {24'd0, pc8}, 32'hF4);
    @(posedge clk); #1;
    check("w8 pc1", {24'd0, pc8}, 32'hF8);
    @(posedge clk); #1;
    check("w8 pc2", {24'd0, pc8}, 32'hFC);
    check("w8 pcplus", {24'd0, pcp8}, 32'h00);
    @(posedge clk); #1;
    check("w8 wrap", {24'd0, pc8}, 32'h00);
    check("w8 valid", {31'd0, val8}, 32'd1);
    check("w8 kernel", {31'd0, kern8}, 32'd0);
    check("w8 cause", {30'd0, cause8}, 32'd0);
    check("w8 trap", {31'd0, trap8}, 32'd0);
    check("w8 epc", {24'd0, epc8}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
